// File: rtl/serial_deser_pkg.sv
// rtl/serial_deser_pkg.sv - shared widths, depths and FSM state type for serial_deser.
// SERIAL_DESER_PARITY_EN adds the PARITY state between DATA and STOP.
package serial_deser_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 2;

`ifdef SERIAL_DESER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } deser_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd3
    } deser_state_t;
`endif

endpackage

// File: rtl/deser_fifo2.sv
// rtl/deser_fifo2.sv - two-entry byte FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is dropped and flagged.
module deser_fifo2
    import serial_deser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              dropped
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dropped   = push && !w_do_push;
    assign dout      = r_mem[r_rd_ptr];

    // When full, wr_ptr equals rd_ptr, so a simultaneous push overwrites the byte being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - LSB-first serial-to-byte deserializer with 2-entry output FIFO.
// Define SERIAL_DESER_PARITY_EN for an even-parity bit after the 8 data bits.
module serial_deser
    import serial_deser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    deser_state_t      r_state;
    deser_state_t      w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_push;
    logic              w_byte_ok;
    logic              w_frame_err_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_dropped;
    logic              r_frame_err;
    logic              r_overrun;

`ifdef SERIAL_DESER_PARITY_EN
    logic r_par_bad;
    logic w_par_bad_nxt;
    logic w_parity_err_nxt;
    logic r_parity_err;

    assign w_byte_ok  = !r_par_bad;
    assign parity_err = r_parity_err;
`else
    assign w_byte_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_dropped;
`ifdef SERIAL_DESER_PARITY_EN
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    // Every state holds still unless bit_en strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_push          = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        w_par_bad_nxt    = r_par_bad;
        w_parity_err_nxt = 1'b0;
`endif
        if (bit_en) begin
            case (r_state)
                IDLE: begin
                    if (!serial_in) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = 3'd0;
`ifdef SERIAL_DESER_PARITY_EN
                        w_par_bad_nxt = 1'b0;
`endif
                    end
                end
                DATA: begin
                    w_shift_nxt   = {serial_in, r_shift[DATA_W-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef SERIAL_DESER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: begin
                    if (serial_in != (^r_shift)) begin
                        w_parity_err_nxt = 1'b1;
                        w_par_bad_nxt    = 1'b1;
                    end
                    w_state_nxt = STOP;
                end
`endif
                STOP: begin
                    if (serial_in) begin
                        w_push = w_byte_ok;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    deser_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (data_ready),
        .dout      (data_out),
        .full      (w_full),
        .empty     (w_empty),
        .dropped   (w_dropped)
    );

    assign data_valid = !w_empty;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `serial_in`, input, 1 bit: serial bit stream, LSB first, idle level 1.
REQ-004 SHALL have port `bit_en`, input, 1 bit: one-cycle strobe; `serial_in` is sampled only when `bit_en`=1.
REQ-005 SHALL have port `data_out`, output, 8 bits: head byte of the output buffer.
REQ-006 SHALL have port `data_valid`, output, 1 bit: `data_out` holds an unread byte.
REQ-007 SHALL have port `data_ready`, input, 1 bit: consumer accepts the byte when `data_valid`=1.
REQ-008 SHALL have port `frame_err`, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port `parity_err`, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-010 SHALL have port `overrun`, output, 1 bit: one-cycle pulse when a completed byte is dropped because the buffer is full.
REQ-011 SHALL have port `busy`, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, DATA, PARITY and STOP; PARITY exists only when PARITY_EN is defined.
REQ-013 IDLE: `bit_en`=1 with `serial_in`=0 (start bit) SHALL move to DATA and clear the bit counter; `serial_in`=1 SHALL stay in IDLE.
REQ-014 DATA: each `bit_en` SHALL right-shift `serial_in` into bit 7 of the assembly register and increment the 3-bit counter; the 8th bit SHALL move to PARITY (if enabled) or to STOP.
REQ-015 STOP: `bit_en` with `serial_in`=1 SHALL push the assembled byte and return to IDLE.
REQ-016 STOP: `bit_en` with `serial_in`=0 SHALL pulse `frame_err`, discard the byte and return to IDLE.
REQ-017 Cycles with `bit_en`=0 SHALL leave FSM state, counter and assembly register unchanged.
REQ-018 Output buffer SHALL be a 2-entry FIFO; `data_valid` SHALL equal not-empty.
REQ-019 The FIFO SHALL pop when `data_valid`=1 and `data_ready`=1.
REQ-020 Latency: a pushed byte SHALL appear on `data_out` with `data_valid`=1 in the cycle after the stop-bit `bit_en` when the FIFO was empty.
REQ-021 A push while the FIFO is full with no pop in the same cycle SHALL drop the new byte, pulse `overrun` and leave FIFO contents unchanged.
REQ-022 A push and pop in the same cycle while the FIFO is full SHALL accept the push, with no `overrun`.
REQ-023 `data_out` SHALL remain stable while `data_valid`=1 and `data_ready`=0.

Reset
REQ-024 `rst_n`=0 SHALL immediately force: FSM=IDLE, counter=0, assembly register=0x00, FIFO empty, `data_out`=0x00, `data_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0.
REQ-025 Reset mid-frame SHALL abandon the partial byte; the first `bit_en` after release SHALL be treated as an IDLE sample.

Configuration
REQ-026 The macro SHALL be named `SERIAL_DESER_PARITY_EN`.
REQ-027 With `SERIAL_DESER_PARITY_EN` defined, one even-parity bit SHALL follow the 8 data bits.
REQ-028 On a parity mismatch, `parity_err` SHALL pulse as the parity bit is sampled; the byte SHALL be discarded and the FSM SHALL still pass through STOP.
REQ-029 With `SERIAL_DESER_PARITY_EN` undefined, there SHALL be no PARITY state and `parity_err` SHALL be tied to 0.

Structure
REQ-030 Package `serial_deser_pkg` SHALL hold the FSM state typedef, DATA_W=8 and FIFO_DEPTH=2.
REQ-031 The FIFO SHALL be a separate sub-module `deser_fifo2`, 8-bit, 2-entry, with push/pop/full/empty.

Verification
REQ-032 Frame 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB first, stop), `data_ready`=1 -> `data_out`=0xA5 with `data_valid` for one cycle, the cycle after the stop `bit_en`.
REQ-033 Stop bit 0 after 0x3C -> `frame_err` pulses once, `data_valid` stays 0, `busy` falls.
REQ-034 Three frames 0x01, 0x02, 0x03 with `data_ready`=0 -> `overrun` pulses on the third; raising `data_ready` then yields 0x01, then 0x02.
REQ-035 FIFO full with `data_ready`=1 in the cycle the third stop bit is sampled -> no `overrun`; bytes 0x01, 0x02, 0x03 delivered in order.
REQ-036 `rst_n` pulsed low after 4 data bits, then a full frame 0x5A -> only 0x5A delivered, with no error pulses.
REQ-037 With PARITY_EN, send 0x07 with parity bit 0 -> `parity_err` pulses and no byte is delivered; with parity bit 1 -> 0x07 is delivered.
